// File: rtl/ones_acc_pkg.sv
// Shared types and constants for the per-frame ones accumulator.
package ones_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width of a single slice's popcount (0..3).
    localparam int PC_W = 2;

    // All-ones value of a w-bit field; used as the saturation ceiling.
    function automatic logic [31:0] all_ones(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ones3_count.sv
// Combinational popcount of a 3-bit slice {a,b,c} -> a+b+c.
module ones3_count
    import ones_acc_pkg::*;
(
    input  logic [2:0]      in_bits,
    output logic [PC_W-1:0] pc
);

    assign pc = {1'b0, in_bits[0]} + {1'b0, in_bits[1]} + {1'b0, in_bits[2]};

endmodule

// File: rtl/ones_frame_accumulator.sv
// Per-frame ones accumulator: counts ones in each accepted 3-bit beat, sums
// them over a frame closed by in_last and presents the total on a
// valid/ready output. Optional macro SATURATE_EN clamps the running total
// at its all-ones value instead of wrapping; out_ovf is the same either way.
module ones_frame_accumulator
    import ones_acc_pkg::*;
#(
    parameter int SUM_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

`ifdef SATURATE_EN
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'(all_ones(SUM_W));
`endif

    state_t           state;
    state_t           next_state;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] beats;
    logic             ovf;
    logic             valid_q;
    logic [SUM_W:0]   sum_ext;
    logic             accept;

    // Extended add: the extra top bit is the carry out of SUM_W.
    function automatic logic [SUM_W:0] add_pc(input logic [SUM_W-1:0] a,
                                              input logic [PC_W-1:0]  p);
        return {1'b0, a} + (SUM_W+1)'(p);
    endfunction

    // Fold the extended sum back to SUM_W bits: wrap, or clamp on carry.
    function automatic logic [SUM_W-1:0] fold_sum(input logic [SUM_W:0] s);
`ifdef SATURATE_EN
        return s[SUM_W] ? SAT_MAX : s[SUM_W-1:0];
`else
        return s[SUM_W-1:0];
`endif
    endfunction

    ones3_count u_count (
        .in_bits (in_bits),
        .pc      (pc)
    );

    assign in_ready  = (state != HOLD);
    assign accept    = in_valid & in_ready;
    assign sum_ext   = add_pc(acc, pc);
    assign out_valid = valid_q;
    assign out_sum   = acc;
    assign out_beats = beats;
    assign out_ovf   = ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: a last beat closes the frame, the output handshake reopens it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    next_state = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Accumulator, beat counter, sticky overflow and the registered output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            beats   <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                if (state == IDLE) begin
                    acc   <= SUM_W'(pc);
                    beats <= CNT_W'(1);
                    ovf   <= 1'b0;
                end else begin
                    acc   <= fold_sum(sum_ext);
                    beats <= beats + CNT_W'(1);
                    ovf   <= ovf | sum_ext[SUM_W];
                end
                if (in_last) begin
                    valid_q <= 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Self-checking bench for ones_frame_accumulator (SUM_W=4, CNT_W=3) with
// directed steps followed by randomized frames against a frame-level model.
module tb_ones_frame_accumulator;

    localparam int SUM_W = 4;
    localparam int CNT_W = 3;
    localparam int SMAX  = (1 << SUM_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_bits;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    ones_frame_accumulator #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame-level reference: results depend only on the frame's total ones and beat count.
    function automatic void model(input int total, input int n,
                                  output int s, output int b, output int o);
        o = (total > SMAX) ? 1 : 0;
`ifdef SATURATE_EN
        s = (total > SMAX) ? SMAX : total;
`else
        s = total % (SMAX + 1);
`endif
        b = n % (1 << CNT_W);
    endfunction

    // Offer one beat at a falling edge and hold it until it is taken.
    task automatic send_beat(input logic [2:0] bits, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bits  = bits;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, check it stays stable for 'hold' stalled cycles, then take it.
    task automatic expect_frame(input int es, input int eb, input int eo, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        for (int i = 0; i <= hold; i++) begin
            chk("out_sum", out_sum, es);
            chk("out_beats", out_beats, eb);
            chk("out_ovf", out_ovf, eo);
            chk("in_ready_hold", in_ready, 0);
            if (i < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clear", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        int total, nb, es, eb, eo;
        logic [2:0] bits;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bits   = 3'b000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Step 1: four-beat frame, total 6.
        send_beat(3'b111, 1'b0);
        send_beat(3'b101, 1'b0);
        send_beat(3'b000, 1'b0);
        chk("t1_no_early_valid", out_valid, 0);
        send_beat(3'b001, 1'b1);
        chk("t1_latency", out_valid, 1);
        expect_frame(6, 4, 0, 0);

        // Step 2: single-beat frame from IDLE.
        send_beat(3'b011, 1'b1);
        chk("t2_valid", out_valid, 1);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_sum", out_sum, 2);
        chk("t2_beats", out_beats, 1);

        // Step 3: backpressure with a beat offered during HOLD.
        in_valid = 1'b1;
        in_bits  = 3'b111;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_in_ready", in_ready, 0);
            chk("t3_valid", out_valid, 1);
            chk("t3_sum", out_sum, 2);
            chk("t3_beats", out_beats, 1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_valid_clr", out_valid, 0);
        chk("t3_ready_back", in_ready, 1);

        // Step 4: six beats of 111 overflow a 4-bit total.
        for (int i = 0; i < 6; i++) send_beat(3'b111, (i == 5));
        model(18, 6, es, eb, eo);
        expect_frame(es, eb, eo, 1);

        // Step 5: reset mid-frame discards the partial frame.
        send_beat(3'b111, 1'b0);
        send_beat(3'b110, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_beats", out_beats, 0);
        chk("t5_rst_sum", out_sum, 0);
        chk("t5_rst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(3'b100, 1'b1);
        expect_frame(1, 1, 0, 0);

        // Step 6: back-to-back frames with the consumer always ready.
        out_ready = 1'b1;
        send_beat(3'b110, 1'b0);
        send_beat(3'b001, 1'b1);
        chk("t6_f1_valid", out_valid, 1);
        chk("t6_f1_sum", out_sum, 3);
        chk("t6_bubble", in_ready, 0);
        send_beat(3'b000, 1'b1);
        chk("t6_f2_valid", out_valid, 1);
        chk("t6_f2_sum", out_sum, 0);
        chk("t6_f2_beats", out_beats, 1);
        @(negedge clk);
        chk("t6_f2_taken", out_valid, 0);
        out_ready = 1'b0;

        // Randomized frames with idle gaps and output stalls.
        for (int f = 0; f < 25; f++) begin
            nb    = $urandom_range(1, 12);
            total = 0;
            for (int b = 0; b < nb; b++) begin
                bits  = 3'($urandom_range(0, 7));
                total = total + $countones(bits);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_beat(bits, (b == nb - 1));
            end
            model(total, nb, es, eb, eo);
            expect_frame(es, eb, eo, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
